// File: rtl/buzzer_tone_gen.sv
// Piezo buzzer square-wave generator: plays notes C4..B4 from a 4-bit code and
// switches notes only on a falling edge. Optional articulation gap: BUZZER_GAP_EN.
module buzzer_tone_gen #(
  parameter int unsigned CLK_FREQ   = 100000000,
  parameter int unsigned GAP_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] note_in,
  input  logic       mute,
  output logic       buzzer,
  output logic [3:0] note_cur,
  output logic       note_active
);

  localparam int unsigned CW = 32;
  localparam int unsigned NW = 4;

  localparam logic [CW-1:0] HALF_C4 = CW'(CLK_FREQ / (2 * 262));
  localparam logic [CW-1:0] HALF_D4 = CW'(CLK_FREQ / (2 * 294));
  localparam logic [CW-1:0] HALF_E4 = CW'(CLK_FREQ / (2 * 330));
  localparam logic [CW-1:0] HALF_F4 = CW'(CLK_FREQ / (2 * 349));
  localparam logic [CW-1:0] HALF_G4 = CW'(CLK_FREQ / (2 * 392));
  localparam logic [CW-1:0] HALF_A4 = CW'(CLK_FREQ / (2 * 440));
  localparam logic [CW-1:0] HALF_B4 = CW'(CLK_FREQ / (2 * 494));

`ifdef BUZZER_GAP_EN
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
`endif

  typedef enum logic [1:0] {
    ST_SILENT = 2'd0,
    ST_TONE   = 2'd1
`ifdef BUZZER_GAP_EN
    , ST_GAP  = 2'd2
`endif
  } state_e;

  function automatic logic [CW-1:0] half_of(input logic [NW-1:0] n);
    logic [CW-1:0] h;
    case (n)
      4'd1:    h = HALF_C4;
      4'd2:    h = HALF_D4;
      4'd3:    h = HALF_E4;
      4'd4:    h = HALF_F4;
      4'd5:    h = HALF_G4;
      4'd6:    h = HALF_A4;
      4'd7:    h = HALF_B4;
      default: h = CW'(1);
    endcase
    return h;
  endfunction

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            phase_q, phase_d;
  logic [NW-1:0]   note_cur_q, note_cur_d;
  logic            buzzer_q, buzzer_d;
  logic            active_q, active_d;
`ifdef BUZZER_GAP_EN
  logic [GW-1:0]   gap_q, gap_d;
  logic            gap_done_c;
`endif

  logic [NW-1:0]   note_eff_c;
  logic [CW-1:0]   half_c;
  logic            boundary_c;
  logic            switch_c;

  // Codes outside 1..7 collapse to rest
  assign note_eff_c = (note_in != 4'd0 && note_in <= 4'd7) ? note_in : 4'd0;
  assign half_c     = half_of(note_cur_q);
  assign boundary_c = (cnt_q == half_c - CW'(1));
  // A pending note change is only honoured at the end of a high half-period
  assign switch_c   = (state_q == ST_TONE) && boundary_c && phase_q
                      && (note_eff_c != note_cur_q);
`ifdef BUZZER_GAP_EN
  assign gap_done_c = (state_q == ST_GAP) && (gap_q == GW'(GAP_CYCLES - 1));
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_SILENT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SILENT: begin
        if (note_eff_c != 4'd0) state_d = ST_TONE;
      end
      ST_TONE: begin
        if (switch_c) begin
`ifdef BUZZER_GAP_EN
          state_d = (note_eff_c == 4'd0) ? ST_SILENT : ST_GAP;
`else
          state_d = (note_eff_c == 4'd0) ? ST_SILENT : ST_TONE;
`endif
        end
      end
`ifdef BUZZER_GAP_EN
      ST_GAP: begin
        if (gap_done_c) state_d = (note_eff_c == 4'd0) ? ST_SILENT : ST_TONE;
      end
`endif
      default: state_d = ST_SILENT;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    note_cur_d = note_cur_q;
`ifdef BUZZER_GAP_EN
    gap_d      = gap_q;
`endif
    case (state_q)
      ST_SILENT: begin
        cnt_d      = '0;
        phase_d    = 1'b0;
        note_cur_d = note_eff_c;
      end
      ST_TONE: begin
        if (boundary_c) begin
          cnt_d = '0;
          if (switch_c) begin
            phase_d    = 1'b0;
            note_cur_d = note_eff_c;
`ifdef BUZZER_GAP_EN
            gap_d      = '0;
`endif
          end else begin
            phase_d = ~phase_q;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef BUZZER_GAP_EN
      ST_GAP: begin
        cnt_d   = '0;
        phase_d = 1'b0;
        if (gap_done_c) begin
          gap_d      = '0;
          note_cur_d = note_eff_c;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
`endif
      default: begin
        cnt_d      = '0;
        phase_d    = 1'b0;
        note_cur_d = '0;
      end
    endcase
    // Mute gates only the pin; the phase keeps running underneath
    buzzer_d = phase_d & ~mute;
    active_d = (state_d != ST_SILENT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      phase_q    <= 1'b0;
      note_cur_q <= '0;
      buzzer_q   <= 1'b0;
      active_q   <= 1'b0;
`ifdef BUZZER_GAP_EN
      gap_q      <= '0;
`endif
    end else begin
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      note_cur_q <= note_cur_d;
      buzzer_q   <= buzzer_d;
      active_q   <= active_d;
`ifdef BUZZER_GAP_EN
      gap_q      <= gap_d;
`endif
    end
  end

  assign buzzer      = buzzer_q;
  assign note_cur    = note_cur_q;
  assign note_active = active_q;

endmodule

// File: tb/tb_buzzer_tone_gen.sv
// Directed self-checking bench for buzzer_tone_gen with CLK_FREQ=5240, GAP_CYCLES=4
// (HALF(1)=10, HALF(6)=5, HALF(7)=5).
module tb_buzzer_tone_gen;

  logic       clk;
  logic       rst;
  logic [3:0] note_in;
  logic       mute;
  logic       buzzer;
  logic [3:0] note_cur;
  logic       note_active;

  int pass_cnt = 0;
  int total    = 0;
  int n;
  logic any_hi;

`ifdef BUZZER_GAP_EN
  localparam int GAP_RISE = 9;
`else
  localparam int GAP_RISE = 5;
`endif

  buzzer_tone_gen #(.CLK_FREQ(5240), .GAP_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .note_in     (note_in),
    .mute        (mute),
    .buzzer      (buzzer),
    .note_cur    (note_cur),
    .note_active (note_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
  endtask

  // Count negedges until buzzer reads v (bounded)
  task automatic wait_level(input logic v, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (buzzer !== v && cnt < 200);
  endtask

  initial begin
    rst = 1'b1; note_in = 4'd0; mute = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_buzzer", int'(buzzer), 0);
    chk("rst_note_cur", int'(note_cur), 0);
    chk("rst_active", int'(note_active), 0);

    // Start C4
    rst = 1'b0; note_in = 4'd1;
    @(negedge clk);
    chk("start_active", int'(note_active), 1);
    chk("start_note_cur", int'(note_cur), 1);
    chk("start_buzzer", int'(buzzer), 0);
    wait_level(1'b1, n); chk("c4_first_rise", n, 10);
    wait_level(1'b0, n); chk("c4_fall", n, 10);
    wait_level(1'b1, n); chk("c4_rise2", n, 10);

    // Change to A4 three samples into a high half
    repeat (2) @(negedge clk);
    note_in = 4'd6;
    wait_level(1'b0, n); chk("switch_fall", n, 8);
    chk("switch_note_cur", int'(note_cur), 6);
    chk("switch_active", int'(note_active), 1);
    wait_level(1'b1, n); chk("a4_first_rise", n, GAP_RISE);
    wait_level(1'b0, n); chk("a4_fall", n, 5);
    wait_level(1'b1, n); chk("a4_rise", n, 5);

    // Mute for 12 cycles starting at a rising edge
    mute = 1'b1;
    any_hi = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      any_hi = any_hi | buzzer;
    end
    chk("mute_low", int'(any_hi), 0);
    chk("mute_note_cur", int'(note_cur), 6);
    mute = 1'b0;
    @(negedge clk);
    chk("unmute_phase", int'(buzzer), 1);
    wait_level(1'b0, n); chk("unmute_fall", n, 2);

    // Rest requested while low; a code-12 value at the switch point counts as rest
    note_in = 4'd0;
    wait_level(1'b1, n); chk("rest_rise", n, 5);
    note_in = 4'd12;
    wait_level(1'b0, n); chk("rest_fall", n, 5);
    chk("rest_active", int'(note_active), 0);
    chk("rest_note_cur", int'(note_cur), 0);

    // Out-of-range code from silence stays silent
    note_in = 4'd9;
    any_hi = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      any_hi = any_hi | buzzer | note_active;
    end
    chk("code9_idle", int'(any_hi), 0);
    chk("code9_note_cur", int'(note_cur), 0);

    // Async reset mid-tone
    note_in = 4'd7;
    wait_level(1'b1, n); chk("b4_rise", n, 6);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_buzzer", int'(buzzer), 0);
    chk("async_rst_active", int'(note_active), 0);
    chk("async_rst_note_cur", int'(note_cur), 0);
    @(negedge clk);
    rst = 1'b0;
    wait_level(1'b1, n); chk("post_rst_rise", n, 6);
    chk("post_rst_note_cur", int'(note_cur), 7);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
